cu_pipe_ctrl: RTL
=================

# cu_pipe_ctrl

Parametrised pipelined control unit for the RISC-V core. Decodes the ID-stage instruction into a control bus and carries it through ID/EX, EX/MEM and MEM/WB control registers. Adds per-stage valid bits, load-use hazard stalling, branch/jump flush, global memory stall and illegal-opcode flagging. Sits between the instruction fetch register and the datapath stage registers.

## Interface

Parameters:
- `M_EXT`, default 0: when 1, decodes RV32M (funct7=0000001, opcode 0110011) into ALU ops 10000–10111.
- `ALUOP_W`, default 4: ALU op width; must be 5 when `M_EXT`=1.
- `CBUS_W`, default 14+`ALUOP_W`: control bus width. Derived; never overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_instr` in 32: instruction in ID.
- `id_valid` in 1: `id_instr` holds a real instruction.
- `id_ready` out 1: ID instruction accepted this cycle; fetch advances only when `id_valid & id_ready`.
- `ex_flush` in 1: branch taken or jump resolved in EX.
- `mem_stall` in 1: data memory not ready; freezes all stages.
- `ex_cbus`, `mem_cbus`, `wb_cbus` out `CBUS_W`: stage control buses.
- `ex_valid`, `mem_valid`, `wb_valid` out 1: stage valid bits.
- `ex_rd`, `mem_rd`, `wb_rd` out 5: destination register per stage.
- `ex_illegal` out 1: instruction in EX had an unrecognised opcode/funct.
- `load_use_stall` out 1: combinational hazard indicator.

## Operation

- **Control bus field order**, LSB first:
  - ImmSrc[2:0], ASrc, BSrc, RegWEn, MemWEn, DdataSel[1:0];
  - ALUop[`ALUOP_W`-1:0];
  - Branch, Jump, BrU, BrT[1:0].
- **DdataSel encoding:** 00 ALU, 01 memory, 10 PC+4.
- **Decode:** combinational from `id_instr`. rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- **Operand use:**
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by R-type, S-type and B-type only.
- **Load-use hazard:** `load_use_stall` = `ex_valid` & EX DdataSel==01 & `ex_rd`≠0 & (ex_rd==rs1 used | ex_rd==rs2 used) & `id_valid`.
- **Per-cycle priority:**
  1. `mem_stall`: every stage register holds. `id_ready`=0.
  2. `ex_flush`: EX loads a bubble. ID instruction is discarded and `id_ready`=1. EX→MEM and MEM→WB advance normally, because the branch itself must complete.
  3. `load_use_stall`: EX loads a bubble, ID holds (`id_ready`=0), MEM/WB advance.
  4. Otherwise: ID→EX, EX→MEM, MEM→WB. `id_ready`=1.
- **Bubble:** valid=0, cbus=0, rd=0, illegal=0. A zero cbus guarantees RegWEn=MemWEn=Branch=Jump=0.
- **`id_valid`=0:** EX loads a bubble.
- **Illegal instruction:** unknown opcode, or M-ext encoding with `M_EXT`=0.
  - Captured with valid=1 and cbus forced to 0; `ex_illegal`=1.
  - Propagates no side effects.
- **rd=x0:** RegWEn is forced to 0 in the decoded bus.
- **Reset:** all valid bits, cbus, rd and `ex_illegal` are 0.

## Timing

- ID→EX latency 1 cycle; EX→MEM 1; MEM→WB 1. An instruction accepted at cycle n appears on `wb_cbus` at n+3 absent stalls.
- `id_ready` and `load_use_stall` are combinational from current inputs and EX state. They have no registered delay.
- A load-use stall lasts exactly one cycle: after the bubble, the load is in MEM and the hazard clears.
- `ex_flush` with `load_use_stall` in the same cycle: flush wins and the stall is dropped.
- `ex_flush` and `mem_stall` in the same cycle: stall wins. The datapath must hold `ex_flush` until `mem_stall` deasserts.
- `rst` asserted mid-operation clears all stages immediately, asynchronously. The first accept can occur the cycle after `rst` deasserts.

## Structure

- **Package `cu_pkg`:**
  - opcode constants;
  - control-bus field offsets and widths as functions of `ALUOP_W`;
  - DdataSel, ImmSrc, BrT and ALUop encodings.
- **Sub-module `cu_decode`:** combinational instruction→{cbus, illegal, rs1_used, rs2_used}, parametrised by `M_EXT`/`ALUOP_W`.
- **Top level:** stage registers and hazard/flush logic only.

## Test plan

- **Reset:** assert `rst` async mid-cycle → all `*_valid`, `*_cbus`, `*_rd` read 0 before the next edge.
- **Straight-line flow:** feed `addi x1,x0,5` (0x00500093) then `add x2,x1,x1` (0x00108133) → no stall; WB shows rd=1 then rd=2 on consecutive cycles 3 and 4 after accept, RegWEn=1.
- **Load-use:** `lw x5,0(x1)` (0x0000A283) then `add x6,x5,x7` (0x00728333) → `load_use_stall`=1 for one cycle, `id_ready`=0, then `ex_valid`=0 bubble, add enters EX next cycle.
- **Flush:** `beq` in EX with `ex_flush`=1 while `lw x5` decoding in ID → lw discarded, `ex_valid`=0 next cycle, beq reaches MEM.
- **Memory stall:** `mem_stall`=1 for 3 cycles with full pipeline → all stage outputs unchanged for 3 cycles, `id_ready`=0; resume with no loss or duplication.
- **M extension:** `mul x3,x1,x2` (0x022081B3) with `M_EXT`=0 → `ex_illegal`=1, cbus=0. With `M_EXT`=1 → ALUop=10000, RegWEn=1.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcodes, control-bus layout and field encodings for the pipelined control unit
// Control bus, LSB first: ImmSrc[2:0], ASrc, BSrc, RegWEn, MemWEn, DdataSel[1:0],
// ALUop[ALUOP_W-1:0], Branch, Jump, BrU, BrT[1:0]. Total width 14+ALUOP_W.
package cu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Fixed-position fields below the ALU op
  localparam int IMM_LSB    = 0;
  localparam int ASRC_BIT   = 3;
  localparam int BSRC_BIT   = 4;
  localparam int REGWEN_BIT = 5;
  localparam int MEMWEN_BIT = 6;
  localparam int DSEL_LSB   = 7;
  localparam int ALUOP_LSB  = 9;

  // Fields above the ALU op move with its width
  function automatic int branch_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w;
  endfunction
  function automatic int jump_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w + 1;
  endfunction
  function automatic int bru_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w + 2;
  endfunction
  function automatic int brt_lsb(input int aluop_w);
    return ALUOP_LSB + aluop_w + 3;
  endfunction
  function automatic int cbus_width(input int aluop_w);
    return ALUOP_LSB + aluop_w + 5;
  endfunction

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_src_e;
  typedef enum logic [1:0] {DSEL_ALU = 2'b00, DSEL_MEM = 2'b01, DSEL_PC4 = 2'b10} dsel_e;
  typedef enum logic [1:0] {BRT_EQ = 2'b00, BRT_NE = 2'b01, BRT_LT = 2'b10, BRT_GE = 2'b11} brt_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB,
    ALU_MUL = 5'b10000, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  // Base-ISA ALU op from funct3; alt selects SUB/SRA (funct7[5])
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational instruction decoder producing the control bus
// Ports: instr (32b instruction) -> cbus (control bus, zero when illegal), illegal,
//        rs1_used/rs2_used (operand read flags), rs1/rs2/rd register fields.
module cu_decode import cu_pkg::*; #(
  parameter int M_EXT   = 0,
  parameter int ALUOP_W = 4,
  parameter int CBUS_W  = 14 + ALUOP_W
) (
  input  logic [31:0]       instr,
  output logic [CBUS_W-1:0] cbus,
  output logic              illegal,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd
);

  localparam int BRANCH_BIT = branch_bit(ALUOP_W);
  localparam int JUMP_BIT   = jump_bit(ALUOP_W);
  localparam int BRU_BIT    = bru_bit(ALUOP_W);
  localparam int BRT_LSB    = brt_lsb(ALUOP_W);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [CBUS_W-1:0] cb;
  logic [4:0]        alu;
  logic              ill;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  always_comb begin
    cb       = '0;
    ill      = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    alu      = ALU_ADD;
    case (opc)
      OPC_LUI: begin
        cb[IMM_LSB +: 3] = IMM_U;
        cb[BSRC_BIT]     = 1'b1;
        cb[REGWEN_BIT]   = 1'b1;
        alu              = ALU_PASSB;
      end
      OPC_AUIPC: begin
        cb[IMM_LSB +: 3] = IMM_U;
        cb[ASRC_BIT]     = 1'b1;
        cb[BSRC_BIT]     = 1'b1;
        cb[REGWEN_BIT]   = 1'b1;
      end
      OPC_JAL: begin
        cb[IMM_LSB +: 3]  = IMM_J;
        cb[ASRC_BIT]      = 1'b1;
        cb[BSRC_BIT]      = 1'b1;
        cb[REGWEN_BIT]    = 1'b1;
        cb[DSEL_LSB +: 2] = DSEL_PC4;
        cb[JUMP_BIT]      = 1'b1;
      end
      OPC_JALR: begin
        cb[IMM_LSB +: 3]  = IMM_I;
        cb[BSRC_BIT]      = 1'b1;
        cb[REGWEN_BIT]    = 1'b1;
        cb[DSEL_LSB +: 2] = DSEL_PC4;
        cb[JUMP_BIT]      = 1'b1;
        rs1_used          = 1'b1;
        ill               = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        cb[IMM_LSB +: 3] = IMM_B;
        cb[ASRC_BIT]     = 1'b1;
        cb[BSRC_BIT]     = 1'b1;
        cb[BRANCH_BIT]   = 1'b1;
        // funct3 {2,0} maps straight onto EQ/NE/LT/GE; funct3[1] marks the unsigned forms
        cb[BRT_LSB +: 2] = brt_e'({f3[2], f3[0]});
        cb[BRU_BIT]      = f3[2] & f3[1];
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        ill              = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        cb[IMM_LSB +: 3]  = IMM_I;
        cb[BSRC_BIT]      = 1'b1;
        cb[REGWEN_BIT]    = 1'b1;
        cb[DSEL_LSB +: 2] = DSEL_MEM;
        rs1_used          = 1'b1;
        ill               = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        cb[IMM_LSB +: 3] = IMM_S;
        cb[BSRC_BIT]     = 1'b1;
        cb[MEMWEN_BIT]   = 1'b1;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        ill              = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        cb[IMM_LSB +: 3] = IMM_I;
        cb[BSRC_BIT]     = 1'b1;
        cb[REGWEN_BIT]   = 1'b1;
        rs1_used         = 1'b1;
        alu              = alu_base(f3, (f3 == 3'b101) && f7[5]);
        // Only the shift-immediates constrain the upper bits
        if (f3 == 3'b001 && f7 != F7_BASE)
          ill = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
          ill = 1'b1;
      end
      OPC_OP: begin
        cb[REGWEN_BIT] = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        if (f7 == F7_MEXT) begin
          if (M_EXT != 0)
            alu = {2'b10, f3};
          else
            ill = 1'b1;
        end else if (f7 == F7_BASE) begin
          alu = alu_base(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          alu = alu_base(f3, 1'b1);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // ALUOP_W must be 5 whenever M_EXT is set, otherwise the M ops alias base ops
    cb[ALUOP_LSB +: ALUOP_W] = alu[ALUOP_W-1:0];
    if (rd == 5'd0)
      cb[REGWEN_BIT] = 1'b0;
  end

  assign illegal = ill;
  assign cbus    = ill ? '0 : cb;

endmodule

// File: rtl/cu_pipe_ctrl.sv
// rtl/cu_pipe_ctrl.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard, flush and stall handling
// Ports: clk, rst (async, active-high); id_instr/id_valid/id_ready (ID handshake);
//        ex_flush (branch/jump resolved in EX); mem_stall (freeze all stages);
//        {ex,mem,wb}_cbus/_valid/_rd (stage state); ex_illegal; load_use_stall (combinational).
module cu_pipe_ctrl import cu_pkg::*; #(
  parameter int M_EXT   = 0,
  parameter int ALUOP_W = 4,
  parameter int CBUS_W  = 14 + ALUOP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic [CBUS_W-1:0] ex_cbus,
  output logic [CBUS_W-1:0] mem_cbus,
  output logic [CBUS_W-1:0] wb_cbus,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [4:0]        ex_rd,
  output logic [4:0]        mem_rd,
  output logic [4:0]        wb_rd,
  output logic              ex_illegal,
  output logic              load_use_stall
);

  logic [CBUS_W-1:0] dec_cbus;
  logic              dec_illegal;
  logic              rs1_used;
  logic              rs2_used;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        dec_rd;
  logic              ex_bubble;

  cu_decode #(
    .M_EXT   (M_EXT),
    .ALUOP_W (ALUOP_W),
    .CBUS_W  (CBUS_W)
  ) u_decode (
    .instr    (id_instr),
    .cbus     (dec_cbus),
    .illegal  (dec_illegal),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (dec_rd)
  );

  // A load in EX cannot forward to the instruction in ID until it reaches MEM
  assign load_use_stall = ex_valid && (ex_cbus[DSEL_LSB +: 2] == DSEL_MEM) && (ex_rd != 5'd0) &&
                          ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2)) && id_valid;

  // Flush consumes the ID instruction (discarded) so fetch may move on
  assign id_ready  = !mem_stall && (ex_flush || !load_use_stall);
  assign ex_bubble = ex_flush || load_use_stall || !id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_cbus    <= '0;
      ex_rd      <= '0;
      ex_illegal <= 1'b0;
      mem_valid  <= 1'b0;
      mem_cbus   <= '0;
      mem_rd     <= '0;
      wb_valid   <= 1'b0;
      wb_cbus    <= '0;
      wb_rd      <= '0;
    end else if (!mem_stall) begin
      mem_valid <= ex_valid;
      mem_cbus  <= ex_cbus;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_cbus   <= mem_cbus;
      wb_rd     <= mem_rd;
      if (ex_bubble) begin
        ex_valid   <= 1'b0;
        ex_cbus    <= '0;
        ex_rd      <= '0;
        ex_illegal <= 1'b0;
      end else begin
        // Illegal instructions travel with valid=1 and an all-zero bus
        ex_valid   <= 1'b1;
        ex_cbus    <= dec_cbus;
        ex_rd      <= dec_rd;
        ex_illegal <= dec_illegal;
      end
    end
  end

endmodule
